// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft-reset requests in, staged domain resets and reset cause out.
interface reset_sequencer_if;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic       reset_done;
  logic [1:0] rst_cause;
  modport master (output sw_rst_req, wdt_rst_req, input periph_rst_n, cpu_rst_n, reset_done, rst_cause);
  modport slave  (input sw_rst_req, wdt_rst_req, output periph_rst_n, cpu_rst_n, reset_done, rst_cause);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises POR release, then frees peripherals before the CPU; handles SW/WDT soft resets.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIPH_HOLD = 16,
  parameter int CPU_HOLD    = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  reset_sequencer_if.slave bus
);
  localparam int MAX_HOLD = PERIPH_HOLD > CPU_HOLD ? PERIPH_HOLD : CPU_HOLD;
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] P_LOAD = CW'(PERIPH_HOLD - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(CPU_HOLD - 1);
  typedef enum logic [2:0] {RESET, SYNC, HOLD_PERIPH, HOLD_CPU, RUN} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   periph_q, periph_d;
  logic                   cpu_q, cpu_d;
  logic [1:0]             cause_q, cause_d;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= RESET;
      sync_q   <= '0;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      cause_q  <= cause_d;
    end
  end
  // Release edge is the one where the last synchroniser stage first fills.
  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d    = cnt_q;
    periph_d = periph_q;
    cpu_d    = cpu_q;
    cause_d  = cause_q;
    case (state_q)
      RESET, SYNC: begin
        state_d = (sync_d[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]) ? HOLD_PERIPH : SYNC;
        cnt_d   = P_LOAD;
      end
      HOLD_PERIPH: begin
        state_d  = cnt_q == '0 ? HOLD_CPU : HOLD_PERIPH;
        cnt_d    = cnt_q == '0 ? C_LOAD : cnt_q - 1'b1;
        periph_d = cnt_q == '0;
      end
      HOLD_CPU: begin
        state_d = cnt_q == '0 ? RUN : HOLD_CPU;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        cpu_d   = cnt_q == '0;
      end
      RUN: begin
        if (bus.sw_rst_req | bus.wdt_rst_req) begin
          state_d  = HOLD_PERIPH;
          cnt_d    = P_LOAD;
          periph_d = 1'b0;
          cpu_d    = 1'b0;
          cause_d  = bus.wdt_rst_req ? 2'b10 : 2'b01;
        end
      end
      default: state_d = RESET;
    endcase
  end
  assign bus.periph_rst_n = periph_q;
  assign bus.cpu_rst_n    = cpu_q;
  assign bus.reset_done   = cpu_q;
  assign bus.rst_cause    = cause_q;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Synchronises the testbench/board power-on reset, stretches it and releases the design's reset domains in a fixed order: peripherals first, then the CPU core. It sits directly downstream of the top-level reset source and drives the active-low resets of the nanorv32 core and its peripherals. It also accepts software and watchdog reset requests and records the cause of the last reset.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `rst` deassertion. Must be ≥ 2.
- `PERIPH_HOLD`, default 16: cycles `periph_rst_n` stays low after the release edge. Must be ≥ 1.
- `CPU_HOLD`, default 8: extra cycles `cpu_rst_n` stays low after `periph_rst_n` rises. Must be ≥ 1.
- `clk_in`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `sw_rst_req`, in, 1: software reset request, synchronous to `clk_in`, level or pulse.
- `wdt_rst_req`, in, 1: watchdog reset request, synchronous to `clk_in`, level or pulse.
- `periph_rst_n`, out, 1: peripheral-domain reset, active-low.
- `cpu_rst_n`, out, 1: CPU-domain reset, active-low.
- `reset_done`, out, 1: high only in RUN.
- `rst_cause`, out, 2: cause of the last reset. 00 = POR, 01 = SW, 10 = WDT. 11 is never driven.

## Operation
- States: RESET, SYNC, HOLD_PERIPH, HOLD_CPU, RUN. One down-counter sized to hold max(`PERIPH_HOLD`, `CPU_HOLD`).
- `rst` high, at any time and in any state:
  - All flops clear asynchronously; state goes to RESET.
  - `periph_rst_n`=0, `cpu_rst_n`=0, `reset_done`=0, `rst_cause`=00.
  - Outputs assert combinationally with no clock needed.
- RESET/SYNC: an `SYNC_STAGES`-deep shift register of 1s clocks in after `rst` falls. The release edge R is the `SYNC_STAGES`-th rising edge sampled with `rst` low. At R the FSM enters HOLD_PERIPH and loads the counter.
- HOLD_PERIPH: counts `PERIPH_HOLD` cycles. On the last one, `periph_rst_n` goes 1 and the FSM enters HOLD_CPU.
- HOLD_CPU: counts `CPU_HOLD` cycles. On the last one, `cpu_rst_n`=1, `reset_done`=1 and the FSM enters RUN.
- RUN: the FSM samples the requests each edge. If either is high at edge S:
  - At S, `periph_rst_n`, `cpu_rst_n` and `reset_done` go 0, registered.
  - `rst_cause` updates at S.
  - The FSM enters HOLD_PERIPH with the counter reloaded, skipping the synchroniser.
- Simultaneous `sw_rst_req` and `wdt_rst_req`: WDT wins, `rst_cause`=10.
- Requests seen in any state other than RUN are ignored and not queued. A level request still high on return to RUN triggers a new soft reset on the first RUN edge.
- `rst_cause` changes only on a soft reset or on `rst`. It holds its value through RUN and through the hold states.
- All outputs come straight from flops. They are glitch-free, except the asynchronous assertion on `rst`.

## Timing
- Reset values: `periph_rst_n`=0, `cpu_rst_n`=0, `reset_done`=0, `rst_cause`=00.
- POR release: `periph_rst_n` rises at edge R+`PERIPH_HOLD`. `cpu_rst_n` and `reset_done` rise at edge R+`PERIPH_HOLD`+`CPU_HOLD`.
- Soft reset with request sampled at S:
  - All three outputs fall at S; `rst_cause` is valid at S.
  - `periph_rst_n` rises at S+`PERIPH_HOLD`.
  - `cpu_rst_n` and `reset_done` rise at S+`PERIPH_HOLD`+`CPU_HOLD`.
- `rst` reasserted mid-sequence (SYNC, HOLD_*, RUN): immediate asynchronous return to RESET. The counter and synchroniser clear, and the full POR timing restarts from the next release.
- `rst` pulse shorter than one clock period: still a full reset and full POR sequence.
- Invariant, checked every cycle: `cpu_rst_n`=1 implies `periph_rst_n`=1, and `reset_done` equals `cpu_rst_n`.

## Test plan
- POR, defaults: hold `rst` high for 5 cycles, then drop it between edges. Required: `periph_rst_n` rises exactly at edge 2+16=18 after the drop, `cpu_rst_n` and `reset_done` at edge 26, `rst_cause`=00 throughout.
- SW reset: in RUN, pulse `sw_rst_req` for 1 cycle at edge S. Required: outputs low at S, `rst_cause`=01, `periph_rst_n` up at S+16, `cpu_rst_n` up at S+24.
- WDT/SW collision: in RUN, raise both requests on the same edge. Required: `rst_cause`=10 and standard soft-reset timing.
- Ignored request: pulse `wdt_rst_req` at S+5 during HOLD_PERIPH of a SW reset. Required: the sequence is unaffected, `rst_cause` stays 01, and no second reset follows.
- Async reset mid-sequence: assert `rst` for 0.3 cycle during HOLD_CPU. Required:
  - Outputs fall immediately without a clock edge.
  - `rst_cause`=00.
  - Full 2+16+8 POR timing follows.
- Parameter sweep: run `SYNC_STAGES`=3, `PERIPH_HOLD`=1, `CPU_HOLD`=1. Required: `periph_rst_n` at edge 4, `cpu_rst_n` at edge 5 after release, with the invariant holding throughout.
